// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared types, constants and helpers for the multiplexed seven-segment driver.
//   seg_t        : segment vector, gfedcba = bit6..bit0, active-high
//   SEG_BLANK    : all segments off
//   SEG_DASH     : g segment only, used to flag a value that does not fit
//   MAX_DIGITS   : largest supported digit count
//   bcd_to_seg() : BCD digit -> segment pattern (non-decimal codes blank)
//   pow10()      : elaboration-time power of ten for overflow limits
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK  = 7'h00;
    localparam seg_t SEG_DASH   = 7'b1000000;
    localparam int   MAX_DIGITS = 8;

    function automatic seg_t bcd_to_seg(input logic [3:0] digit);
        seg_t seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial
// Serial double-dabble converter: one shift-add-3 step per clock.
//   clk    in  1              clock, rising edge
//   rst    in  1              asynchronous active-high reset, aborts conversion
//   start  in  1              capture value and begin (honoured only when idle)
//   value  in  VALUE_WIDTH    binary input
//   busy   out 1              high for exactly VALUE_WIDTH cycles after start
//   done   out 1              high during the final step cycle
//   bcd    out 4*NUM_DIGITS   result of the current step; valid while done=1
// The result is presented combinationally on the final step so the parent can
// commit it on the same edge that drops busy. BCD bits beyond NUM_DIGITS digits
// fall off the top of the shift register; lower digits stay correct
// (value mod 10**NUM_DIGITS) because add-3 corrections only carry upward.
// -----------------------------------------------------------------------------
module bin_to_bcd_serial #(
    parameter int VALUE_WIDTH = 14,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [VALUE_WIDTH-1:0]    value,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(VALUE_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t                  state_reg;
    logic                    busy_reg;
    logic [VALUE_WIDTH-1:0]  bin_reg;
    logic [BW-1:0]           bcd_reg;
    logic [CW-1:0]           cnt_reg;

    logic [BW-1:0]           adj;
    logic [BW-1:0]           bcd_step;

    // Add 3 to every digit that is 5 or more before the shift doubles it.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            always_comb begin
                adj[4*gi +: 4] = bcd_reg[4*gi +: 4];
                if (bcd_reg[4*gi +: 4] >= 4'd5) begin
                    adj[4*gi +: 4] = bcd_reg[4*gi +: 4] + 4'd3;
                end
            end
        end
    endgenerate

    assign bcd_step = {adj[BW-2:0], bin_reg[VALUE_WIDTH-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        bin_reg   <= value;
                        bcd_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bin_reg <= bin_reg << 1;
                    bcd_reg <= bcd_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = (state_reg == ST_SHIFT) && (cnt_reg == LAST_STEP);
    assign bcd  = bcd_step;

endmodule

// File: rtl/multi_digit_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// multi_digit_seven_seg_scanner
// Multiplexed seven-segment driver with serial binary-to-BCD conversion,
// leading-zero blanking, per-digit decimal points, overflow dashes and blink.
//   clock_1KHz  in  1            scan clock, rising edge
//   reset       in  1            asynchronous active-high reset
//   load        in  1            capture value when load & !busy at an edge
//   value       in  VALUE_WIDTH  binary value to display
//   busy        out 1            conversion in progress, load ignored
//   lzb_en      in  1            blank leading zeros (ones digit never blanked)
//   blink_en    in  1            blink the whole display
//   dp          in  NUM_DIGITS   decimal point per digit, bit 0 = LSB digit
//   display     out 7            segments gfedcba, active-high, registered
//   dp_out      out 1            decimal point of lit digit, registered
//   digitSelect out DSW          binary index of lit digit, registered
// The stored digits and the overflow flag change together on the conversion's
// final edge, so the scan keeps showing the previous value until then.
// -----------------------------------------------------------------------------
module multi_digit_seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int VALUE_WIDTH  = 14,
    parameter int BLINK_PERIOD = 500,
    localparam int DSW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clock_1KHz,
    input  logic                    reset,
    input  logic                    load,
    input  logic [VALUE_WIDTH-1:0]  value,
    output logic                    busy,
    input  logic                    lzb_en,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [6:0]              display,
    output logic                    dp_out,
    output logic [DSW-1:0]          digitSelect
);

    localparam int BCW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_PERIOD - 1);
    localparam logic [DSW-1:0] SCAN_LAST  = DSW'(NUM_DIGITS - 1);

    // Overflow threshold. When every representable value fits in NUM_DIGITS
    // digits the compare is dropped and the flag is tied low.
    localparam longint unsigned LIMIT = pow10(NUM_DIGITS);
    localparam bit OVF_POSSIBLE = (64'd1 << VALUE_WIDTH) > LIMIT;
    localparam logic [VALUE_WIDTH:0] LIMIT_W = (VALUE_WIDTH + 1)'(LIMIT);

    logic                     conv_start;
    logic                     conv_busy;
    logic                     conv_done;
    logic [4*NUM_DIGITS-1:0]  conv_bcd;
    logic                     ovf_now;

    logic                     ovf_pending_reg;
    logic                     ovf_reg;
    logic [3:0]               digits_reg [NUM_DIGITS];
    logic [DSW-1:0]           scan_reg;
    logic [BCW-1:0]           blink_cnt_reg;
    logic                     blink_on_reg;
    seg_t                     display_reg;
    logic                     dp_out_reg;

    logic [DSW-1:0]           scan_next;
    logic [NUM_DIGITS-1:0]    upper_zero;
    logic [3:0]               sel_digit;
    logic                     lz_blank;
    logic                     blink_on_eff;
    seg_t                     seg_next;
    logic                     dp_next;

    assign conv_start = load & ~conv_busy;

    bin_to_bcd_serial #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_conv (
        .clk   (clock_1KHz),
        .rst   (reset),
        .start (conv_start),
        .value (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    generate
        if (OVF_POSSIBLE) begin : g_ovf
            assign ovf_now = ({1'b0, value} >= LIMIT_W);
        end else begin : g_no_ovf
            assign ovf_now = 1'b0;
        end
    endgenerate

    // Digit store, written only when a conversion completes.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_store
            always_ff @(posedge clock_1KHz or posedge reset) begin
                if (reset) begin
                    digits_reg[gi] <= 4'd0;
                end else if (conv_done) begin
                    digits_reg[gi] <= conv_bcd[4*gi +: 4];
                end
            end
        end
    endgenerate

    // upper_zero[i]: digits i..NUM_DIGITS-1 are all zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign upper_zero[gi] = (digits_reg[gi] == 4'd0);
            end else begin : g_mid
                assign upper_zero[gi] = (digits_reg[gi] == 4'd0) & upper_zero[gi+1];
            end
        end
    endgenerate

    // The output registers are loaded for the digit the scan moves to, so
    // digitSelect and the segments always change on the same edge.
    assign scan_next    = (scan_reg == SCAN_LAST) ? '0 : scan_reg + 1'b1;
    assign sel_digit    = digits_reg[scan_next];
    assign lz_blank     = lzb_en && (scan_next != '0) && upper_zero[scan_next];
    assign blink_on_eff = blink_on_reg | ~blink_en;

    always_comb begin
        seg_next = bcd_to_seg(sel_digit);
        dp_next  = dp[scan_next];
        if (!blink_on_eff) begin
            seg_next = SEG_BLANK;
            dp_next  = 1'b0;
        end else if (ovf_reg) begin
            seg_next = SEG_DASH;
        end else if (lz_blank) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clock_1KHz or posedge reset) begin
        if (reset) begin
            scan_reg        <= '0;
            blink_cnt_reg   <= '0;
            blink_on_reg    <= 1'b1;
            display_reg     <= SEG_BLANK;
            dp_out_reg      <= 1'b0;
            ovf_pending_reg <= 1'b0;
            ovf_reg         <= 1'b0;
        end else begin
            scan_reg    <= scan_next;
            display_reg <= seg_next;
            dp_out_reg  <= dp_next;

            // Blink counter free-runs; blink_en only masks its effect.
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                blink_on_reg  <= ~blink_on_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end

            // Overflow is judged on the captured value but only becomes
            // visible together with the digits it belongs to.
            if (conv_start) begin
                ovf_pending_reg <= ovf_now;
            end
            if (conv_done) begin
                ovf_reg <= ovf_pending_reg;
            end
        end
    end

    assign busy        = conv_busy;
    assign display     = display_reg;
    assign dp_out      = dp_out_reg;
    assign digitSelect = scan_reg;

endmodule

// File: tb/tb_multi_digit_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// Directed bench for multi_digit_seven_seg_scanner (4 digits, 14-bit value,
// blink half-period of 4 clocks). Expected scan entries are queued from a
// reference model when stimulus is applied and popped as the DUT scans.
// -----------------------------------------------------------------------------
module tb_multi_digit_seven_seg_scanner;

    localparam int N  = 4;
    localparam int VW = 14;
    localparam int BP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [VW-1:0] value;
    logic          busy;
    logic          lzb_en;
    logic          blink_en;
    logic [N-1:0]  dp;
    logic [6:0]    display;
    logic          dp_out;
    logic [1:0]    digit_select;

    int total  = 0;
    int passed = 0;

    typedef struct {
        int         idx;
        logic [6:0] seg;
        logic       dpo;
    } exp_t;

    exp_t sb[$];

    // Edges since reset release, used to predict the blink phase.
    int unsigned ec;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ec <= 0;
        else     ec <= ec + 1;
    end

    multi_digit_seven_seg_scanner #(
        .NUM_DIGITS   (N),
        .VALUE_WIDTH  (VW),
        .BLINK_PERIOD (BP)
    ) dut (
        .clock_1KHz  (clk),
        .reset       (rst),
        .load        (load),
        .value       (value),
        .busy        (busy),
        .lzb_en      (lzb_en),
        .blink_en    (blink_en),
        .dp          (dp),
        .display     (display),
        .dp_out      (dp_out),
        .digitSelect (digit_select)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic exp_t model(input int val, input int idx, input bit lzb,
                                   input logic [N-1:0] dpv, input bit on);
        exp_t e;
        int   p;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        e.idx = idx;
        if (!on) begin
            e.seg = 7'h00;
            e.dpo = 1'b0;
        end else if (val >= 10000) begin
            e.seg = 7'h40;
            e.dpo = dpv[idx];
        end else if (lzb && idx > 0 && val < p) begin
            e.seg = 7'h00;
            e.dpo = dpv[idx];
        end else begin
            e.seg = seg_of((val / p) % 10);
            e.dpo = dpv[idx];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_scan(input int val, input bit lzb);
        for (int i = 0; i < N; i++) sb.push_back(model(val, i, lzb, dp, 1'b1));
    endtask

    task automatic drain_scan(input string tag);
        for (int k = 0; k < 8 && digit_select !== 2'd3; k++) tick();
        check({tag, "_align"}, digit_select, 3);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tick();
            check({tag, "_sel"}, digit_select, e.idx);
            check({tag, "_seg"}, display, e.seg);
            check({tag, "_dp"}, dp_out, e.dpo);
        end
    endtask

    task automatic do_load(input int v);
        int n;
        for (int k = 0; k < 40 && busy !== 1'b0; k++) tick();
        check("idle_before_load", busy, 0);
        value = VW'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("busy_len", n, 14);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        lzb_en   = 1'b0;
        blink_en = 1'b0;
        dp       = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_display", display, 7'h00);
        check("rst_dp_out", dp_out, 0);
        check("rst_sel", digit_select, 0);
        rst = 1'b0;

        // Idle after reset, no blanking: every digit shows 0.
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_sel", digit_select, (k + 1) % 4);
            check("idle_seg", display, 7'h3F);
            check("idle_busy", busy, 0);
        end

        do_load(1234);
        push_scan(1234, 1'b0);
        drain_scan("v1234");

        lzb_en = 1'b1;
        do_load(7);
        push_scan(7, 1'b1);
        drain_scan("v7_lzb");

        dp = 4'b0100;
        do_load(0);
        push_scan(0, 1'b1);
        drain_scan("v0_dp");

        dp = 4'b0000;
        do_load(12000);
        push_scan(12000, 1'b1);
        drain_scan("v12000_ovf");

        do_load(9999);
        push_scan(9999, 1'b1);
        drain_scan("v9999");

        // Load 55, then attempt 99 on the third busy cycle.
        value = VW'(55);
        load  = 1'b1;
        tick();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 2) begin
                value = VW'(99);
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            n++;
            tick();
        end
        load = 1'b0;
        check("ignored_busy_len", n, 14);
        push_scan(55, 1'b1);
        drain_scan("v55_keep");

        // Reset in the middle of a conversion.
        value = VW'(55);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (5) tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_display", display, 7'h00);
        check("mid_rst_dp_out", dp_out, 0);
        check("mid_rst_sel", digit_select, 0);
        tick();
        rst = 1'b0;
        push_scan(0, 1'b1);
        drain_scan("post_rst");
        repeat (20) tick();
        check("post_rst_busy", busy, 0);
        push_scan(0, 1'b1);
        drain_scan("no_late_commit");

        // Blink: phase predicted from edges since reset release.
        dp       = 4'b1111;
        blink_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_t e;
            sb.push_back(model(0, (digit_select + 1) % 4, 1'b1, dp, ((ec / BP) % 2) == 0));
            tick();
            e = sb.pop_front();
            check("blink_sel", digit_select, e.idx);
            check("blink_seg", display, e.seg);
            check("blink_dp", dp_out, e.dpo);
        end

        blink_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            sb.push_back(model(0, (digit_select + 1) % 4, 1'b1, dp, 1'b1));
            tick();
            e = sb.pop_front();
            check("steady_seg", display, e.seg);
            check("steady_dp", dp_out, e.dpo);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
